// File: rtl/wait_state_mem.sv
// wait_state_mem: word memory whose every access completes after a fixed number of wait states.
// Supports byte/halfword/word lanes, sign or zero extension on reads, and flags illegal lane masks.
module wait_state_mem #(
    parameter int ADDR_BITS   = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CS,
    input  logic        RW,
    input  logic [3:0]  BE,
    input  logic        MemSign,
    input  logic [31:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        DataReady,
    output logic        Busy,
    output logic        Error
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic rw_q, sign_q;
    logic [3:0] be_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic [31:0] din_q;
    logic [31:0] mem [2**ADDR_BITS];
    logic idle, accept, rw_s, sign_s, legal;
    logic [3:0] be_s;
    logic [ADDR_BITS-1:0] idx_s;
    logic [31:0] word, rd_data;
    logic [7:0] rd_b;
    logic [15:0] rd_h;
    logic unused_addr;
    assign unused_addr = ^{Addr[31:ADDR_BITS+2], Addr[1:0]};
    assign idle = state == S_IDLE;
    assign accept = idle && CS;
    // With zero wait states DONE is entered on the accepting edge, so read data comes straight from the inputs then
    assign rw_s = idle ? RW : rw_q;
    assign sign_s = idle ? MemSign : sign_q;
    assign be_s = idle ? BE : be_q;
    assign idx_s = idle ? Addr[ADDR_BITS+1:2] : idx_q;
    assign word = mem[idx_s];
    assign DataReady = state == S_DONE;
    assign Busy = !idle;
    always_comb begin
        legal = be_s inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rd_b = be_s[3] ? word[31:24] : be_s[2] ? word[23:16] : be_s[1] ? word[15:8] : word[7:0];
        rd_h = be_s[3] ? word[31:16] : word[15:0];
        rd_data = !legal ? 32'd0 :
                  be_s == 4'b1111 ? word :
                  (be_s == 4'b0011 || be_s == 4'b1100) ? {{16{sign_s & rd_h[15]}}, rd_h} :
                  {{24{sign_s & rd_b[7]}}, rd_b};
    end
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        if (accept) begin
            state_d = WC == 4'd0 ? S_DONE : S_WAIT;
            cnt_d = WC;
        end else if (state == S_WAIT) begin
            state_d = cnt <= 4'd1 ? S_DONE : S_WAIT;
            cnt_d = cnt - 4'd1;
        end else if (state == S_DONE) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt <= 4'd0;
            DataOut <= 32'd0;
            Error <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            if (accept) begin
                rw_q <= RW;
                be_q <= BE;
                sign_q <= MemSign;
                idx_q <= Addr[ADDR_BITS+1:2];
                din_q <= DataIn;
            end
            if (state_d == S_DONE && state != S_DONE) begin
                Error <= !legal;
                if (!rw_s)
                    DataOut <= rd_data;
            end
        end
    end
    // Writes commit on leaving DONE so a reset anywhere before then drops them
    always_ff @(posedge Clk) begin
        if (!Reset && state == S_DONE && rw_q && legal)
            for (int i = 0; i < 4; i++)
                if (be_q[i])
                    mem[idx_q][8*i +: 8] <= din_q[8*i +: 8];
    end
endmodule
